// File: rtl/axil_read_responder.sv
// axil_read_responder: AXI4-Lite read slave serving a local register bank
// through a 1-cycle lookup port, with an in-order response FIFO on R.
module axil_read_responder #(
  parameter int TCQ = 1,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter logic [S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int REG_AWIDTH = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        reg_rd_en,
  output logic [REG_AWIDTH-1:0]       reg_rd_index,
  input  logic [S_AXI_DATA_WIDTH-1:0] reg_rd_data,
  output logic [15:0]                 rd_err_count
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]               r_wptr, r_rptr;
  logic [CW-1:0]               r_count;
  logic                        r_pend_valid, r_pend_err, r_reg_rd_en;
  logic [REG_AWIDTH-1:0]       r_reg_rd_index;
  logic [15:0]                 r_err_count;
  logic [S_AXI_DATA_WIDTH-1:0] r_mem_data [RESP_DEPTH];
  logic [1:0]                  r_mem_resp [RESP_DEPTH];
  logic                        w_in_range, w_accept, w_pop, w_unused;
  assign w_in_range = s_axi_araddr[S_AXI_ADDR_WIDTH-1:REG_AWIDTH+2] == BASE_ADDR[S_AXI_ADDR_WIDTH-1:REG_AWIDTH+2];
  // The pending S1 entry reserves a FIFO slot so a push can never overflow.
  assign s_axi_arready = s_axi_aresetn && ((r_count + CW'(r_pend_valid)) < CW'(RESP_DEPTH));
  assign w_accept = s_axi_arvalid && s_axi_arready;
  assign s_axi_rvalid = r_count != '0;
  assign w_pop = s_axi_rvalid && s_axi_rready;
  assign s_axi_rdata = r_mem_data[r_rptr];
  assign s_axi_rresp = r_mem_resp[r_rptr];
  assign reg_rd_en = r_reg_rd_en;
  assign reg_rd_index = r_reg_rd_index;
  assign rd_err_count = r_err_count;
  assign w_unused = ^{s_axi_arprot, s_axi_araddr[1:0], 1'(TCQ)};
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_pend_valid <= 1'b0;
      r_pend_err <= 1'b0;
      r_reg_rd_en <= 1'b0;
      r_reg_rd_index <= '0;
      r_err_count <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_resp[i] <= '0;
      end
    end else begin
      r_pend_valid <= w_accept;
      r_pend_err <= w_accept && !w_in_range;
      r_reg_rd_en <= w_accept && w_in_range;
      if (w_accept && w_in_range) r_reg_rd_index <= s_axi_araddr[REG_AWIDTH+1:2];
      if (r_pend_valid) begin
        r_mem_data[r_wptr] <= r_pend_err ? '0 : reg_rd_data;
        r_mem_resp[r_wptr] <= {2{r_pend_err}};
        r_wptr <= r_wptr + 1'b1;
      end
      if (r_pend_valid && r_pend_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(r_pend_valid) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_axil_read_responder.sv
// tb_axil_read_responder: directed and random reads against a queue model of
// outstanding requests that predicts arready, rvalid, R order and error count.
module tb_axil_read_responder;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic        arready, rvalid, reg_rd_en;
  logic [31:0] rdata, reg_rd_data;
  logic [1:0]  rresp;
  logic [3:0]  reg_rd_index;
  logic [15:0] rd_err_count;
  logic [31:0] regs [16];
  logic [33:0] q [$];
  logic        last_acc = 1'b0, last_ok = 1'b0;
  logic [3:0]  last_idx = '0;
  int          err_m = 0, checks = 0, passes = 0;

  always #5 clk = ~clk;

  assign reg_rd_data = reg_rd_en ? regs[reg_rd_index] : 32'hBAD0_0BAD;

  axil_read_responder dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .reg_rd_en(reg_rd_en), .reg_rd_index(reg_rd_index),
    .reg_rd_data(reg_rd_data), .rd_err_count(rd_err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rresp"}, rresp, 0);
    chk({tag, "_rd_en"}, reg_rd_en, 0);
    chk({tag, "_rd_index"}, reg_rd_index, 0);
    chk({tag, "_err_count"}, rd_err_count, 0);
  endtask

  // Outstanding = accepted but not yet returned; the newest accept is still a cycle from the FIFO.
  always @(negedge clk) begin
    if (!aresetn) begin
      q.delete();
      last_acc = 1'b0;
      err_m = 0;
    end else begin
      chk("m_arready", arready, q.size() < 4);
      chk("m_rvalid", rvalid, (q.size() - int'(last_acc)) > 0);
      chk("m_rd_en", reg_rd_en, last_acc && last_ok);
      if (last_acc && last_ok) chk("m_rd_index", reg_rd_index, last_idx);
      chk("m_err_count", rd_err_count, 16'(err_m - int'(last_acc && !last_ok)));
      if (rvalid && q.size() > 0) chk("m_r_head", {rresp, rdata}, q[0]);
      if (rvalid && rready && q.size() > 0) void'(q.pop_front());
      last_acc = arvalid && arready;
      if (last_acc) begin
        last_ok = araddr[31:6] == '0;
        last_idx = araddr[5:2];
        q.push_back(last_ok ? {2'b00, regs[araddr[5:2]]} : {2'b11, 32'h0});
        if (!last_ok) err_m++;
      end
    end
  end

  initial begin
    int acc, beats;
    for (int i = 0; i < 16; i++) regs[i] = $urandom();
    regs[3] = 32'hDEADBEEF;
    step();
    chk_zero("reset");
    step();
    aresetn = 1'b1;
    @(negedge clk);
    chk("idle_arready", arready, 1);
    chk("idle_rvalid", rvalid, 0);
    // single OKAY read
    step();
    rready = 1'b1;
    araddr = 32'h0C;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("ok_rd_en", reg_rd_en, 1);
    chk("ok_rd_index", reg_rd_index, 3);
    step();
    chk("ok_rvalid", rvalid, 1);
    chk("ok_rdata", rdata, 32'hDEADBEEF);
    chk("ok_rresp", rresp, 2'b00);
    // out-of-range read
    step();
    araddr = 32'h40;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("err_rd_en", reg_rd_en, 0);
    step();
    chk("err_rvalid", rvalid, 1);
    chk("err_rdata", rdata, 0);
    chk("err_rresp", rresp, 2'b11);
    chk("err_count1", rd_err_count, 1);
    // backpressure: six cycles of held arvalid with R stalled
    step();
    rready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      araddr = 32'(acc * 4);
      arvalid = 1'b1;
      @(negedge clk);
      if (arready) acc++;
      step();
    end
    arvalid = 1'b0;
    chk("full_accepts", acc, 4);
    chk("full_arready", arready, 0);
    rready = 1'b1;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid && rready) beats++;
      step();
    end
    chk("full_beats", beats, 4);
    chk("full_arready_back", arready, 1);
    // streaming OKAY, DECERR, OKAY
    arvalid = 1'b1;
    araddr = 32'h00;
    step();
    araddr = 32'h80;
    chk("st_arready0", arready, 1);
    step();
    araddr = 32'h04;
    chk("st_arready1", arready, 1);
    chk("st_rvalid0", rvalid, 1);
    chk("st_rresp0", rresp, 2'b00);
    step();
    arvalid = 1'b0;
    chk("st_rvalid1", rvalid, 1);
    chk("st_rresp1", rresp, 2'b11);
    step();
    chk("st_rvalid2", rvalid, 1);
    chk("st_rresp2", rresp, 2'b00);
    step();
    chk("st_rvalid3", rvalid, 0);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      arvalid = $urandom_range(0, 3) != 0;
      araddr = ($urandom_range(0, 3) == 0) ? ($urandom() | 32'h40) : {26'b0, 6'($urandom())};
      rready = $urandom_range(0, 2) != 0;
      step();
    end
    arvalid = 1'b0;
    rready = 1'b1;
    repeat (10) step();
    chk("rnd_drained", q.size(), 0);
    chk("rnd_rvalid", rvalid, 0);
    // reset with responses in flight
    rready = 1'b0;
    arvalid = 1'b1;
    araddr = 32'h08;
    step();
    araddr = 32'h44;
    step();
    araddr = 32'h10;
    step();
    arvalid = 1'b0;
    step();
    step();
    chk("rst_pre_rvalid", rvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk_zero("rst_mid");
    step();
    step();
    aresetn = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_stale", rvalid, 0);
    end
    araddr = 32'h14;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("rst_rd_en", reg_rd_en, 1);
    chk("rst_rd_index", reg_rd_index, 5);
    step();
    chk("rst_rvalid", rvalid, 1);
    chk("rst_rdata", rdata, regs[5]);
    chk("rst_rresp", rresp, 2'b00);
    step();
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
